// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU-side signal bundle for alu_arbiter
interface alu_arbiter_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a0;
    logic [7:0] req_b0;
    logic [3:0] req_op0;
    logic [7:0] req_a1;
    logic [7:0] req_b1;
    logic [3:0] req_op1;

    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       rsp_err;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;

    logic       busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        output req_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err,
        input  rsp_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero, alu_carry,
        output busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err,
        output rsp_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero, alu_carry,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter of two requesters onto one shared combinational ALU
module alu_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   gnt;
    logic   sel;
    logic   accept;
    logic   legal;
    logic   arith;

    assign sel    = (bus.req_valid == 2'b11) ? prio : bus.req_valid[1];
    // rst_n gates acceptance so req_ready stays low while reset is held
    assign accept = rst_n && (state == IDLE) && (bus.req_valid != 2'b00);
    assign legal  = (bus.alu_op <= 4'd8);
    assign arith  = (bus.alu_op <= 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready[gnt]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        bus.busy      = (state != IDLE);
        if (accept) begin
            bus.req_ready = sel ? 2'b10 : 2'b01;
        end
        if (state == RESP) begin
            bus.rsp_valid = gnt ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio           <= 1'b0;
            gnt            <= 1'b0;
            bus.alu_a      <= 8'd0;
            bus.alu_b      <= 8'd0;
            bus.alu_op     <= 4'd0;
            bus.rsp_result <= 8'd0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                gnt        <= sel;
                prio       <= ~sel;
                bus.alu_a  <= sel ? bus.req_a1  : bus.req_a0;
                bus.alu_b  <= sel ? bus.req_b1  : bus.req_b0;
                bus.alu_op <= sel ? bus.req_op1 : bus.req_op0;
            end
            if (state == EXEC) begin
                // illegal opcodes never sample the ALU, whose outputs are undefined for them
                if (legal) begin
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_zero   <= bus.alu_zero;
                    bus.rsp_carry  <= arith ? bus.alu_carry : 1'b0;
                    bus.rsp_err    <= 1'b0;
                end else begin
                    bus.rsp_result <= 8'd0;
                    bus.rsp_zero   <= 1'b0;
                    bus.rsp_carry  <= 1'b0;
                    bus.rsp_err    <= 1'b1;
                end
            end
        end
    end
endmodule
